// File: rtl/unix_load_arbiter.sv
// Round-robin arbiter sharing the Unix-seconds counter load port between the time editor (A)
// and the serial sync receiver (B). Optional readback check enabled by `define UNIX_LOAD_CHECK_EN.
module unix_load_arbiter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         run,
  input  logic         req_a,
  input  logic [N-1:0] data_a,
  input  logic         hold_a,
  output logic         ack_a,
  input  logic         req_b,
  input  logic [N-1:0] data_b,
  input  logic         hold_b,
  output logic         ack_b,
  input  logic [N-1:0] counter_q,
  output logic         load_n,
  output logic         go,
  output logic [N-1:0] set_counter,
  output logic         busy,
  output logic         load_err,
  output logic [7:0]   load_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic         last_gnt_b_q;
  logic         load_n_q;
  logic         go_q;
  logic         ack_a_q;
  logic         ack_b_q;
  logic         busy_q;
  logic         load_err_q;
  logic [N-1:0] set_counter_q;
  logic [7:0]   load_cnt_q;
  logic         any_req;
  logic         win_a;

  assign any_req = req_a | req_b;
  // A wins when alone, or on a tie when B was granted last.
  assign win_a   = req_a & (~req_b | last_gnt_b_q);

`ifdef UNIX_LOAD_CHECK_EN
  logic readback_ok;
  // The counter is paused during CHECK, but one extra tick is tolerated.
  assign readback_ok = (counter_q == set_counter_q) ||
                       (counter_q == (set_counter_q + N'(1)));
`else
  logic unused_counter_q;
  assign unused_counter_q = ^counter_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = LOAD;
      end
      LOAD: begin
`ifdef UNIX_LOAD_CHECK_EN
        state_d = CHECK;
`else
        state_d = IDLE;
`endif
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_gnt_b_q  <= 1'b1;
      load_n_q      <= 1'b1;
      go_q          <= 1'b0;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      busy_q        <= 1'b0;
      load_err_q    <= 1'b0;
      set_counter_q <= '0;
      load_cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != IDLE);
      go_q     <= run & ~hold_a & ~hold_b & (state_d == IDLE);
      load_n_q <= 1'b1;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            load_n_q      <= 1'b0;
            ack_a_q       <= win_a;
            ack_b_q       <= ~win_a;
            set_counter_q <= win_a ? data_a : data_b;
            last_gnt_b_q  <= ~win_a;
          end
        end
        LOAD: begin
          if (load_cnt_q != 8'hFF) load_cnt_q <= load_cnt_q + 8'd1;
        end
        CHECK: begin
`ifdef UNIX_LOAD_CHECK_EN
          if (!readback_ok) load_err_q <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign load_n      = load_n_q;
  assign go          = go_q;
  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign busy        = busy_q;
  assign load_err    = load_err_q;
  assign set_counter = set_counter_q;
  assign load_cnt    = load_cnt_q;

endmodule

// File: tb/tb_unix_load_arbiter.sv
// Scoreboard bench for unix_load_arbiter: grants are predicted from the arbitration rules when
// requests are issued; a monitor pops and compares on every ack and checks per-cycle outputs.
`timescale 1ns/1ps
module tb_unix_load_arbiter;
  localparam int N = 64;
`ifdef UNIX_LOAD_CHECK_EN
  localparam int  BUSY_CYC = 2;
  localparam bit  ERR_EXP  = 1'b1;
`else
  localparam int  BUSY_CYC = 1;
  localparam bit  ERR_EXP  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         run = 1'b0;
  logic         req_a = 1'b0, hold_a = 1'b0, req_b = 1'b0, hold_b = 1'b0;
  logic [N-1:0] data_a = '0, data_b = '0;
  logic [N-1:0] counter_q;
  logic         ack_a, ack_b, load_n, go, busy, load_err;
  logic [N-1:0] set_counter;
  logic [7:0]   load_cnt;

  always #10 clk = ~clk;

  unix_load_arbiter #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .req_a(req_a), .data_a(data_a), .hold_a(hold_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .hold_b(hold_b), .ack_b(ack_b),
    .counter_q(counter_q), .load_n(load_n), .go(go), .set_counter(set_counter),
    .busy(busy), .load_err(load_err), .load_cnt(load_cnt)
  );

  // Downstream seconds counter, with knobs to fake a bad readback.
  logic [N-1:0] ctr;
  logic [N-1:0] ctr_ofs = '0;
  bit           ctr_bad = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ctr <= '0;
    else if (!load_n) ctr <= set_counter;
    else if (go)      ctr <= ctr + 64'd1;
  end
  assign counter_q = ctr_bad ? 64'h1234 : (ctr + ctr_ofs);

  typedef struct packed {
    logic         win_a;
    logic [N-1:0] data;
  } grant_t;

  grant_t       sb[$];
  bit           ack_log[$];
  int           n_chk = 0, n_fail = 0;
  bit           rand_mode = 1'b0, hold_mode = 1'b0;

  // Reference model: busy cycles remaining, fairness pointer, completed-load count, sticky error.
  int           m_left = 0;
  bit           m_fresh = 1'b0;
  bit           m_last_b = 1'b1;
  int           m_cnt = 0;
  bit           m_err = 1'b0;
  logic [N-1:0] m_data = '0;
  bit           exp_busy = 1'b0, exp_go = 1'b0, exp_load_n = 1'b1;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_fresh = 1'b0; m_last_b = 1'b1; m_cnt = 0; m_err = 1'b0;
    exp_busy = 1'b0; exp_go = 1'b0; exp_load_n = 1'b1;
    sb.delete();
  endtask

  // Predict what the coming rising edge does, from the inputs now applied.
  task automatic predict();
    bit     wa;
    grant_t g;
    if (m_left > 0) begin
      m_left--;
      if (m_fresh) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else if (m_left == 0 && counter_q != m_data && counter_q != m_data + 64'd1) m_err = 1'b1;
      m_fresh = 1'b0;
    end else if (req_a || req_b) begin
      wa       = (req_a && req_b) ? m_last_b : req_a;
      m_data   = wa ? data_a : data_b;
      g.win_a  = wa;
      g.data   = m_data;
      sb.push_back(g);
      m_last_b = !wa;
      m_left   = BUSY_CYC;
      m_fresh  = 1'b1;
    end
    exp_busy   = (m_left > 0);
    exp_go     = run && !hold_a && !hold_b && (m_left == 0);
    exp_load_n = !m_fresh;
  endtask

  task automatic cycle();
    predict();
    @(negedge clk);
    if (!hold_mode) begin
      if (ack_a) req_a = 1'b0;
      else if (rand_mode && !req_a && $urandom_range(0, 2) == 0) begin
        req_a = 1'b1; data_a = {$urandom, $urandom};
      end
      if (ack_b) req_b = 1'b0;
      else if (rand_mode && !req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1'b1; data_b = {$urandom, $urandom};
      end
    end
    if (rand_mode) begin
      run    = ($urandom_range(0, 9) != 0);
      hold_a = ($urandom_range(0, 7) == 0);
      hold_b = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    grant_t g;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        chk("busy", busy, exp_busy);
        chk("go", go, exp_go);
        chk("load_n", load_n, exp_load_n);
        chk("load_cnt", load_cnt, m_cnt);
        chk("load_err", load_err, m_err);
        chk("ack_overlap", ack_a & ack_b, 0);
        if (ack_a || ack_b) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_unexpected_ack: ack_a=%b ack_b=%b with no grant pending", ack_a, ack_b);
          end else begin
            g = sb.pop_front();
            chk("winner_is_a", ack_a, g.win_a);
            chk("set_counter", set_counter, g.data);
            ack_log.push_back(ack_a);
          end
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run = 1'b1;

    // Idle with run: go rises after the first edge.
    cycle();
    chk("reset_go", go, 1);
    chk("reset_load_n", load_n, 1);
    chk("reset_busy", busy, 0);

    // Single editor load.
    req_a = 1'b1; data_a = 64'h66CB_0000;
    cycle();
    chk("a_ack", ack_a, 1);
    chk("a_load_n", load_n, 0);
    chk("a_set_counter", set_counter, 64'h66CB_0000);
    chk("a_go", go, 0);
    repeat (3) cycle();
    chk("a_load_cnt", load_cnt, 1);
    chk("a_ack_gone", ack_a, 0);

    // Both raised together and held for exactly four grants.
    do_reset();
    ack_log.delete();
    hold_mode = 1'b1; req_a = 1'b1; req_b = 1'b1;
    data_a = 64'hAAAA_0001; data_b = 64'hBBBB_0002;
    repeat (4 * (BUSY_CYC + 1)) cycle();
    hold_mode = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (3) cycle();
    chk("rr_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("rr_order_a", ack_log[i], (i % 2 == 0));

    // Readback: +1 is tolerated, garbage sets a sticky flag (check build only).
    ctr_ofs = 64'd1; req_a = 1'b1; data_a = 64'h5678;
    repeat (4) cycle();
    chk("err_plus1", load_err, 0);
    ctr_ofs = '0; ctr_bad = 1'b1; req_a = 1'b1; data_a = 64'h5678;
    repeat (4) cycle();
    chk("err_bad", load_err, ERR_EXP);
    ctr_bad = 1'b0; req_b = 1'b1; data_b = 64'h9999;
    repeat (4) cycle();
    chk("err_sticky", load_err, ERR_EXP);

    // Asynchronous reset in the middle of LOAD.
    req_a = 1'b1; data_a = {$urandom, $urandom};
    cycle();
    chk("rst_in_load", load_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_load_n", load_n, 1);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_go", go, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    req_a = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) cycle();
    chk("rst_load_cnt", load_cnt, 0);

    // hold_b gates go one cycle later.
    hold_b = 1'b1;
    cycle();
    chk("hold_go_low", go, 0);
    hold_b = 1'b0;
    cycle();
    chk("hold_go_high", go, 1);

    // Saturation of the load counter.
    hold_mode = 1'b1; req_a = 1'b1; req_b = 1'b1;
    data_a = {$urandom, $urandom}; data_b = {$urandom, $urandom};
    repeat (270 * (BUSY_CYC + 1)) cycle();
    hold_mode = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (4) cycle();
    chk("load_cnt_sat", load_cnt, 255);

    // Randomised traffic against the model.
    do_reset();
    rand_mode = 1'b1;
    repeat (1500) cycle();
    rand_mode = 1'b0; run = 1'b1; hold_a = 1'b0; hold_b = 1'b0;
    repeat (12) cycle();
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
